// File: rtl/alu_issue_queue.sv
// Queue of ALU operations feeding an external combinational ALU; the result plus its command is held in an output register.
// Optional macro ALU_ISSUE_BYPASS_EN lets an op arriving at an empty queue go straight to the ALU (1 cycle instead of 2).
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic [2:0]               in_cmd,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [2:0]               alu_cmd,
    input  logic [31:0]              alu_result,
    input  logic                     alu_carryout,
    input  logic                     alu_zero,
    input  logic                     alu_overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic                     out_carryout,
    output logic                     out_zero,
    output logic                     out_overflow,
    output logic [2:0]               out_cmd,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_DEPTH = (PW+1)'(DEPTH);

    logic [31:0]   q_a   [DEPTH];
    logic [31:0]   q_b   [DEPTH];
    logic [2:0]    q_cmd [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic empty;
    logic push;
    logic out_free;
    logic issue_q;
    logic enq;
    logic issue;

    assign empty    = (count == '0);
    assign in_ready = (count < CNT_DEPTH);
    assign push     = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;
    assign issue_q  = !empty && out_free;

`ifdef ALU_ISSUE_BYPASS_EN
    logic bypass;
    assign bypass = empty && push && out_free;
    assign enq    = push && !bypass;
    assign issue  = issue_q || bypass;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cmd = '0;
        if (bypass) begin
            alu_a   = in_a;
            alu_b   = in_b;
            alu_cmd = in_cmd;
        end else if (!empty) begin
            alu_a   = q_a[rd_ptr];
            alu_b   = q_b[rd_ptr];
            alu_cmd = q_cmd[rd_ptr];
        end
    end
`else
    assign enq   = push;
    assign issue = issue_q;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cmd = '0;
        if (!empty) begin
            alu_a   = q_a[rd_ptr];
            alu_b   = q_b[rd_ptr];
            alu_cmd = q_cmd[rd_ptr];
        end
    end
`endif

    // Entry storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_a[wr_ptr]   <= in_a;
            q_b[wr_ptr]   <= in_b;
            q_cmd[wr_ptr] <= in_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue_q) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, issue_q})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Data fields hold after the consumer takes a result; only out_valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carryout <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_cmd      <= '0;
        end else if (issue) begin
            out_valid    <= 1'b1;
            out_result   <= alu_result;
            out_carryout <= alu_carryout;
            out_zero     <= alu_zero;
            out_overflow <= alu_overflow;
            out_cmd      <= alu_cmd;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queued operation entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents an operation.
REQ-005 in_ready  output  1  queue can accept an operation this cycle.
REQ-006 in_a / in_b  input  32 each  operandA / operandB.
REQ-007 in_cmd  input  3  ALU command: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
REQ-008 alu_a / alu_b  output  32 each  operands driven to the downstream combinational ALU.
REQ-009 alu_cmd  output  3  command driven to the ALU.
REQ-010 alu_result  input  32; alu_carryout, alu_zero, alu_overflow  input  1 each  ALU outputs, valid same cycle.
REQ-011 out_valid  output  1  registered result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_result  output  32; out_carryout, out_zero, out_overflow  output  1 each; out_cmd  output  3  registered ALU outputs plus the command that produced them.
REQ-014 count  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-015 Push: in_valid && in_ready writes {in_a,in_b,in_cmd} at write pointer; pointer wraps modulo DEPTH.
REQ-016 in_ready SHALL be (count < DEPTH), derived from registered count only; no same-cycle pop-enables-push at full.
REQ-017 Issue condition: queue non-empty && (!out_valid || out_ready).
REQ-018 alu_a/alu_b/alu_cmd SHALL combinationally reflect the head entry when non-empty, else all zero.
REQ-019 On issue: output register captures alu_result, alu_carryout, alu_zero, alu_overflow, head cmd; out_valid=1; head popped; read pointer wraps modulo DEPTH.
REQ-020 out_valid && out_ready without issue: out_valid clears; out_* data holds its last value.
REQ-021 out_valid && !out_ready: output register and head entry SHALL hold unchanged (no issue).
REQ-022 Simultaneous push and issue: count unchanged; both pointers advance.
REQ-023 Latency (macro off): accept at edge N -> ALU driven during cycle N+1 -> out_valid at edge N+1's successor (2 cycles accept-to-out_valid); throughput one op/cycle with out_ready held high.
REQ-024 Operations SHALL complete strictly in acceptance order; no drop, no duplication.
REQ-025 Push when full is impossible by REQ-016; in_valid while !in_ready SHALL have no effect.

Reset
REQ-026 reset=1 at an edge: count=0, pointers=0, out_valid=0, out_result=0, out_carryout=0, out_zero=0, out_overflow=0, out_cmd=000.
REQ-027 Reset mid-operation discards all queued and held entries; in_ready=1 the cycle after reset deasserts.
REQ-028 Reset overrides simultaneous push/issue in the same cycle.

Configuration
REQ-029 Macro ALU_ISSUE_BYPASS_EN defined: when queue empty, in_valid && in_ready, and (!out_valid || out_ready), ALU is driven directly from in_a/in_b/in_cmd and the result captured at that edge without writing the queue (1-cycle accept-to-out_valid).
REQ-030 Macro undefined: every operation passes through the queue (REQ-023 latency); bypass logic absent.

Verification
REQ-031 Reset then push ADD a=0x7FFFFFFF b=0x00000001, out_ready=1 -> out_result=0x80000000, out_overflow=1, out_carryout=0, out_cmd=000 after 2 cycles (1 with ALU_ISSUE_BYPASS_EN).
REQ-032 Push SLT a=0xFFFFFFFF b=0x00000001 then SUB a=5 b=5 back-to-back -> results in order: 0x00000001 then 0x00000000 with out_zero=1, out_carryout=1.
REQ-033 Hold out_ready=0, push 6 ops with DEPTH=4 -> in_ready low once count=4 (one op held in output register), release out_ready -> all 5 accepted ops emerge in order, one per cycle.
REQ-034 Continuous push and out_ready=1 for 10 ops -> count stays constant, pointers wrap past DEPTH, no gaps in out_valid after fill.
REQ-035 Assert reset with count=3 and out_valid=1 -> next cycle count=0, out_valid=0, out_result=0; subsequent push of OR a=0xF0 b=0x0F yields 0x000000FF.
